// File: rtl/bp_stream_mmio_arbiter_pkg.sv
// Shared types and helpers for the host stream MMIO arbiter.
package bp_stream_mmio_arbiter_pkg;

   typedef enum logic {
      e_idle = 1'b0,
      e_lock = 1'b1
   } arb_state_e;

   // Width needed to count 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small first-word-fall-through FIFO; a word written at an edge is readable the next cycle.
module bsg_fifo_1r1w_small
   import bp_stream_mmio_arbiter_pkg::*;
#(
   parameter int width_p = 1,
   parameter int els_p   = 8
)
(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w = cnt_width(els_p);
   localparam int cnt_w = $clog2(els_p + 1);

   logic [width_p-1:0] mem_reg [els_p];
   logic [ptr_w-1:0]   wptr_reg, rptr_reg;
   logic [cnt_w-1:0]   count_reg;
   logic               enq, deq;

   assign ready_o = (count_reg != cnt_w'(els_p));
   assign v_o     = (count_reg != '0);
   assign data_o  = mem_reg[rptr_reg];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   always_ff @(posedge clk_i) begin
      if (enq) mem_reg[wptr_reg] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (enq) wptr_reg <= (wptr_reg == ptr_w'(els_p - 1)) ? '0 : wptr_reg + 1'b1;
         if (deq) rptr_reg <= (rptr_reg == ptr_w'(els_p - 1)) ? '0 : rptr_reg + 1'b1;
         if (enq & ~deq)      count_reg <= count_reg + 1'b1;
         else if (deq & ~enq) count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/bp_stream_mmio_arbiter.sv
// Shares one host stream link between several stream MMIO requesters: whole-packet
// round-robin on the command side, issue-order routing of read responses on the return side.
module bp_stream_mmio_arbiter
   import bp_stream_mmio_arbiter_pkg::*;
#(
   parameter int num_req_p           = 2,
   parameter int stream_data_width_p = 32,
   parameter int pkt_words_p         = 2,
   parameter int resp_words_p        = 2,
   parameter int order_els_p         = 8
)
(
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [num_req_p-1:0]                   req_v_i,
   input  logic [num_req_p*stream_data_width_p-1:0] req_data_i,
   input  logic [num_req_p-1:0]                   req_resp_i,
   output logic [num_req_p-1:0]                   req_yumi_o,
   output logic                                   stream_v_o,
   output logic [stream_data_width_p-1:0]         stream_data_o,
   input  logic                                   stream_yumi_i,
   input  logic                                   stream_v_i,
   input  logic [stream_data_width_p-1:0]         stream_data_i,
   output logic                                   stream_ready_o,
   output logic [num_req_p-1:0]                   resp_v_o,
   output logic [stream_data_width_p-1:0]         resp_data_o,
   input  logic [num_req_p-1:0]                   resp_ready_i
);

   localparam int gnt_w  = $clog2(num_req_p);
   localparam int wcnt_w = cnt_width(pkt_words_p);
   localparam int rcnt_w = cnt_width(resp_words_p);

   arb_state_e                   state_reg, state_next;
   logic [gnt_w-1:0]             gnt_reg, gnt_next, rr_ptr_reg, rr_ptr_next;
   logic [gnt_w-1:0]             pick_idx, cur_gnt, head;
   logic [gnt_w:0]               scan_idx;
   logic [wcnt_w-1:0]            word_cnt_reg, word_cnt_next;
   logic [rcnt_w-1:0]            resp_cnt_reg, resp_cnt_next;
   logic [stream_data_width_p-1:0] req_data_arr [num_req_p];
   logic pick_v, grant_v, fwd_v, fwd_yumi, queue_ready, queue_v, push, pop, resp_xfer;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      pick_v   = 1'b0;
      pick_idx = '0;
      scan_idx = '0;
      for (int i = 0; i < num_req_p; i++) begin
         scan_idx = {1'b0, rr_ptr_reg} + (gnt_w+1)'(i);
         if (scan_idx >= (gnt_w+1)'(num_req_p)) scan_idx = scan_idx - (gnt_w+1)'(num_req_p);
         if (!pick_v && req_v_i[scan_idx[gnt_w-1:0]]) begin
            pick_v   = 1'b1;
            pick_idx = scan_idx[gnt_w-1:0];
         end
      end
   end

   assign cur_gnt       = (state_reg == e_lock) ? gnt_reg : pick_idx;
   assign grant_v       = (state_reg == e_lock) | (pick_v & queue_ready);
   assign fwd_v         = ~reset_i & grant_v & req_v_i[cur_gnt];
   assign fwd_yumi      = fwd_v & stream_yumi_i;
   assign stream_v_o    = fwd_v;
   assign stream_data_o = req_data_arr[cur_gnt];
   assign push          = fwd_yumi & (state_reg == e_idle) & req_resp_i[cur_gnt];

   assign stream_ready_o = ~reset_i & queue_v & resp_ready_i[head];
   assign resp_xfer      = stream_v_i & stream_ready_o;
   assign pop            = resp_xfer & (resp_cnt_reg == rcnt_w'(resp_words_p - 1));
   assign resp_data_o    = stream_data_i;

   genvar gi;
   generate
      for (gi = 0; gi < num_req_p; gi++) begin : g_req
         assign req_data_arr[gi] = req_data_i[gi*stream_data_width_p +: stream_data_width_p];
         assign req_yumi_o[gi]   = fwd_yumi & (cur_gnt == gnt_w'(gi));
         assign resp_v_o[gi]     = ~reset_i & queue_v & stream_v_i & (head == gnt_w'(gi));
      end
   endgenerate

   bsg_fifo_1r1w_small #(
      .width_p (gnt_w),
      .els_p   (order_els_p)
   ) order_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (push),
      .ready_o (queue_ready),
      .data_i  (cur_gnt),
      .v_o     (queue_v),
      .data_o  (head),
      .yumi_i  (pop)
   );

   always_comb begin
      state_next    = state_reg;
      gnt_next      = gnt_reg;
      rr_ptr_next   = rr_ptr_reg;
      word_cnt_next = word_cnt_reg;
      resp_cnt_next = resp_cnt_reg;
      case (state_reg)
         e_idle: if (fwd_yumi) begin
            gnt_next = cur_gnt;
            if (pkt_words_p == 1) begin
               rr_ptr_next = (cur_gnt == gnt_w'(num_req_p - 1)) ? '0 : cur_gnt + 1'b1;
            end else begin
               word_cnt_next = wcnt_w'(1);
               state_next    = e_lock;
            end
         end
         e_lock: if (fwd_yumi) begin
            if (word_cnt_reg == wcnt_w'(pkt_words_p - 1)) begin
               state_next    = e_idle;
               word_cnt_next = '0;
               rr_ptr_next   = (gnt_reg == gnt_w'(num_req_p - 1)) ? '0 : gnt_reg + 1'b1;
            end else begin
               word_cnt_next = word_cnt_reg + 1'b1;
            end
         end
         default: state_next = e_idle;
      endcase
      if (resp_xfer) resp_cnt_next = pop ? '0 : resp_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg    <= e_idle;
         gnt_reg      <= '0;
         rr_ptr_reg   <= '0;
         word_cnt_reg <= '0;
         resp_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         gnt_reg      <= gnt_next;
         rr_ptr_reg   <= rr_ptr_next;
         word_cnt_reg <= word_cnt_next;
         resp_cnt_reg <= resp_cnt_next;
      end
   end

endmodule

// File: tb/tb_bp_stream_mmio_arbiter.sv
// Directed bench for the stream MMIO arbiter with hand-computed expected values.
module tb_bp_stream_mmio_arbiter;

   localparam int N = 2;
   localparam int W = 32;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic [N-1:0]   req_v_i, req_resp_i, req_yumi_o, resp_v_o, resp_ready_i;
   logic [N*W-1:0] req_data_i;
   logic           stream_v_o, stream_yumi_i, stream_v_i, stream_ready_o;
   logic [W-1:0]   stream_data_o, stream_data_i, resp_data_o;

   int total = 0;
   int bad   = 0;

   bp_stream_mmio_arbiter dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .req_v_i        (req_v_i),
      .req_data_i     (req_data_i),
      .req_resp_i     (req_resp_i),
      .req_yumi_o     (req_yumi_o),
      .stream_v_o     (stream_v_o),
      .stream_data_o  (stream_data_o),
      .stream_yumi_i  (stream_yumi_i),
      .stream_v_i     (stream_v_i),
      .stream_data_i  (stream_data_i),
      .stream_ready_o (stream_ready_o),
      .resp_v_o       (resp_v_o),
      .resp_data_o    (resp_data_o),
      .resp_ready_i   (resp_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic host(input logic v, input logic [W-1:0] d, input logic [N-1:0] rdy);
      stream_v_i    = v;
      stream_data_i = d;
      resp_ready_i  = rdy;
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [N-1:0] rsp, input logic y);
      req_v_i       = v;
      req_data_i    = {d1, d0};
      req_resp_i    = rsp;
      stream_yumi_i = y;
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      host(1'b0, '0, '0);
      drive('0, '0, '0, '0, 1'b0);
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i = 1'b1;
      host(1'b0, '0, '0);
      drive('0, '0, '0, '0, 1'b0);

      // reset: outputs gated even with everything asserted
      host(1'b1, 32'h1111_1111, 2'b11);
      drive(2'b11, 32'h1, 32'h2, 2'b11, 1'b1);
      tick();
      check("rst_stream_v", stream_v_o, 0);
      check("rst_yumi", req_yumi_o, 0);
      check("rst_stream_ready", stream_ready_o, 0);
      check("rst_resp_v", resp_v_o, 0);

      // single write from r1
      do_reset();
      host(1'b1, 32'h1234, 2'b11);
      drive(2'b10, '0, 32'h8000_0010, 2'b00, 1'b1);
      check("wr_v0", stream_v_o, 1);
      check("wr_d0", stream_data_o, 32'h8000_0010);
      check("wr_yumi0", req_yumi_o, 2'b10);
      check("wr_ready0", stream_ready_o, 0);
      check("wr_resp_v0", resp_v_o, 0);
      tick();
      drive(2'b10, '0, 32'hDEAD_BEEF, 2'b00, 1'b1);
      check("wr_d1", stream_data_o, 32'hDEAD_BEEF);
      check("wr_yumi1", req_yumi_o, 2'b10);
      check("wr_ready1", stream_ready_o, 0);
      tick();
      drive(2'b00, '0, '0, 2'b00, 1'b1);
      check("wr_idle_v", stream_v_o, 0);
      check("wr_no_queue", stream_ready_o, 0);

      // contention: r0, r0, r1, r1, r0
      do_reset();
      drive(2'b11, 32'h00A0_0000, 32'h00B0_0000, 2'b00, 1'b1);
      check("ct_d0", stream_data_o, 32'h00A0_0000);
      check("ct_y0", req_yumi_o, 2'b01);
      tick();
      drive(2'b11, 32'h00A0_0001, 32'h00B0_0000, 2'b00, 1'b1);
      check("ct_d1", stream_data_o, 32'h00A0_0001);
      check("ct_y1", req_yumi_o, 2'b01);
      tick();
      drive(2'b11, 32'h00A0_0002, 32'h00B0_0000, 2'b00, 1'b1);
      check("ct_d2", stream_data_o, 32'h00B0_0000);
      check("ct_y2", req_yumi_o, 2'b10);
      tick();
      drive(2'b11, 32'h00A0_0002, 32'h00B0_0001, 2'b00, 1'b1);
      check("ct_d3", stream_data_o, 32'h00B0_0001);
      check("ct_y3", req_yumi_o, 2'b10);
      tick();
      drive(2'b11, 32'h00A0_0002, 32'h00B0_0002, 2'b00, 1'b1);
      check("ct_d4", stream_data_o, 32'h00A0_0002);
      check("ct_y4", req_yumi_o, 2'b01);

      // two reads (r1 then r0) overlapped with responses A..D
      do_reset();
      host(1'b0, '0, 2'b11);
      drive(2'b10, '0, 32'h8000_0100, 2'b10, 1'b1);
      check("rd_y0", req_yumi_o, 2'b10);
      check("rd_ready_empty", stream_ready_o, 0);
      tick();
      host(1'b1, 32'hAAAA_0001, 2'b11);
      drive(2'b10, '0, 32'h8000_0101, 2'b10, 1'b1);
      check("rd_d1", stream_data_o, 32'h8000_0101);
      check("rd_A_v", resp_v_o, 2'b10);
      check("rd_A_ready", stream_ready_o, 1);
      check("rd_A_data", resp_data_o, 32'hAAAA_0001);
      tick();
      host(1'b1, 32'hBBBB_0002, 2'b11);
      drive(2'b01, 32'h8000_0200, '0, 2'b01, 1'b1);
      check("rd_d2", stream_data_o, 32'h8000_0200);
      check("rd_y2", req_yumi_o, 2'b01);
      check("rd_B_v", resp_v_o, 2'b10);
      tick();
      host(1'b1, 32'hCCCC_0003, 2'b11);
      drive(2'b01, 32'h8000_0201, '0, 2'b01, 1'b1);
      check("rd_y3", req_yumi_o, 2'b01);
      check("rd_C_v", resp_v_o, 2'b01);
      check("rd_C_data", resp_data_o, 32'hCCCC_0003);
      tick();
      host(1'b1, 32'hDDDD_0004, 2'b11);
      drive(2'b00, '0, '0, 2'b00, 1'b0);
      check("rd_D_v", resp_v_o, 2'b01);
      check("rd_D_ready", stream_ready_o, 1);
      tick();
      host(1'b1, 32'hEEEE_0005, 2'b11);
      #1;
      check("rd_E_ready", stream_ready_o, 0);
      check("rd_E_v", resp_v_o, 2'b00);

      // queue full: eight reads outstanding block the ninth
      do_reset();
      host(1'b0, '0, 2'b01);
      for (int k = 0; k < 16; k++) begin
         drive(2'b01, 32'h0000_1000 + k, '0, 2'b01, 1'b1);
         check($sformatf("qf_y%0d", k), req_yumi_o, 2'b01);
         tick();
      end
      drive(2'b01, 32'h0000_2000, '0, 2'b01, 1'b1);
      check("qf_block_v", stream_v_o, 0);
      check("qf_block_y", req_yumi_o, 2'b00);
      tick();
      host(1'b1, 32'h5555_0001, 2'b00);
      #1;
      check("bp_ready", stream_ready_o, 0);
      check("bp_resp_v", resp_v_o, 2'b01);
      check("bp_block_v", stream_v_o, 0);
      tick();
      host(1'b1, 32'h5555_0001, 2'b01);
      #1;
      check("qf_r1_ready", stream_ready_o, 1);
      check("qf_r1_v", stream_v_o, 0);
      tick();
      host(1'b1, 32'h5555_0002, 2'b01);
      #1;
      check("qf_r2_v", stream_v_o, 0);
      tick();
      host(1'b0, '0, 2'b01);
      #1;
      check("qf_grant_v", stream_v_o, 1);
      check("qf_grant_y", req_yumi_o, 2'b01);

      // host yumi withheld and requester valid dropped mid-packet
      do_reset();
      drive(2'b11, 32'h00A0_0000, 32'h00B0_0000, 2'b00, 1'b1);
      check("hy_y0", req_yumi_o, 2'b01);
      tick();
      drive(2'b11, 32'h00A0_0001, 32'h00B0_0000, 2'b00, 1'b0);
      check("hy_hold_v", stream_v_o, 1);
      check("hy_hold_d", stream_data_o, 32'h00A0_0001);
      check("hy_hold_y", req_yumi_o, 2'b00);
      tick();
      drive(2'b10, 32'h00A0_0001, 32'h00B0_0000, 2'b00, 1'b1);
      check("hy_drop_v", stream_v_o, 0);
      check("hy_drop_y", req_yumi_o, 2'b00);
      tick();
      drive(2'b11, 32'h00A0_0001, 32'h00B0_0000, 2'b00, 1'b1);
      check("hy_resume_d", stream_data_o, 32'h00A0_0001);
      check("hy_resume_y", req_yumi_o, 2'b01);
      tick();
      drive(2'b11, 32'h00A0_0002, 32'h00B0_0000, 2'b00, 1'b1);
      check("hy_next_d", stream_data_o, 32'h00B0_0000);
      check("hy_next_y", req_yumi_o, 2'b10);

      // reset in the middle of an r1 read packet
      do_reset();
      drive(2'b10, '0, 32'h00B0_0000, 2'b10, 1'b1);
      check("rm_y0", req_yumi_o, 2'b10);
      tick();
      reset_i = 1'b1;
      host(1'b1, 32'h7777_0000, 2'b11);
      drive(2'b11, 32'h00A0_0000, 32'h00B0_0001, 2'b11, 1'b1);
      check("rm_v", stream_v_o, 0);
      check("rm_y", req_yumi_o, 2'b00);
      check("rm_ready", stream_ready_o, 0);
      check("rm_resp_v", resp_v_o, 2'b00);
      tick();
      reset_i = 1'b0;
      drive(2'b11, 32'h00A0_0000, 32'h00B0_0001, 2'b00, 1'b1);
      check("rm_after_d", stream_data_o, 32'h00A0_0000);
      check("rm_after_y", req_yumi_o, 2'b01);
      check("rm_after_ready", stream_ready_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
